seq_control: RTL

Fetch/decode/execute sequencer for the accumulator machine. It drives write enables and mux selects for the PC, MAR, MBR, IR and ACC registers, the MainMemory write enable, and the ALU opcode. It sits between the IR output and the register/memory strobes, replacing the empty control stub in the top-level computer. It is a pure controller: no datapath storage other than its own state and counters.

---
 rtl/seq_control.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_control.sv
// Fetch/decode/execute sequencer for the accumulator machine: drives register
// load strobes, datapath mux selects, memory write enable and ALU opcode.
module seq_control #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        acc_zero,
    input  logic        acc_neg,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        mar_write,
    output logic        mar_sel,
    output logic        mbr_write,
    output logic        mbr_sel,
    output logic        ir_write,
    output logic        acc_write,
    output logic        acc_sel,
    output logic        mem_write,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        error,
    output logic [15:0] instr_count
);

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY - 1);

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_SHL   = 4'h7;
    localparam logic [3:0] OP_SHR   = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JNEG  = 4'hB;
    localparam logic [3:0] OP_CMPEQ = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_SHR = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_EQ  = 4'b1111;

    typedef enum logic [3:0] {
        IDLE, F_ADDR, F_WAIT, F_LOAD, DECODE, EXEC,
        E_WAIT, E_READ, E_ACC, E_WRITE, HALTED
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                error_q, error_d;
    logic [3:0]          opcode;
    logic                unused_addr;

    // Opcode sits directly above the address field; the address itself is datapath-only.
    assign opcode      = instr[ADDR_W +: 4];
    assign unused_addr = ^instr[ADDR_W-1:0];
    assign instr_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        count_d   = count_q;
        error_d   = error_q;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        mar_write = 1'b0;
        mar_sel   = 1'b0;
        mbr_write = 1'b0;
        mbr_sel   = 1'b0;
        ir_write  = 1'b0;
        acc_write = 1'b0;
        acc_sel   = 1'b0;
        mem_write = 1'b0;
        alu_op    = ALU_ADD;
        halted    = 1'b0;
        error     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = F_ADDR;
            end
            F_ADDR: begin
                mar_write = 1'b1;
                wait_d    = WAIT_INIT;
                state_d   = F_WAIT;
            end
            F_WAIT: begin
                if (wait_q == '0) state_d = F_LOAD;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            F_LOAD: begin
                mbr_write = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                count_d  = count_q + CNT_W'(1);
                state_d  = EXEC;
            end
            EXEC: begin
                state_d = F_ADDR;
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMPEQ: begin
                        mar_write = 1'b1;
                        mar_sel   = 1'b1;
                        wait_d    = WAIT_INIT;
                        state_d   = E_WAIT;
                    end
                    OP_STORE: begin
                        mar_write = 1'b1;
                        mar_sel   = 1'b1;
                        mbr_write = 1'b1;
                        mbr_sel   = 1'b1;
                        state_d   = E_WRITE;
                    end
                    OP_SHL, OP_SHR: begin
                        acc_write = 1'b1;
                        alu_op    = (opcode == OP_SHL) ? ALU_SHL : ALU_SHR;
                    end
                    OP_JUMP, OP_JZ, OP_JNEG: begin
                        if ((opcode == OP_JUMP) || (opcode == OP_JZ && acc_zero) ||
                            (opcode == OP_JNEG && acc_neg)) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                        end
                    end
                    OP_HALT: begin
                        error_d = 1'b0;
                        state_d = HALTED;
                    end
                    OP_ILL: begin
                        error_d = 1'b1;
                        state_d = HALTED;
                    end
                    default: ;
                endcase
            end
            E_WAIT: begin
                if (wait_q == '0) state_d = E_READ;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            E_READ: begin
                mbr_write = 1'b1;
                state_d   = E_ACC;
            end
            E_ACC: begin
                acc_write = 1'b1;
                acc_sel   = (opcode == OP_LOAD);
                case (opcode)
                    OP_SUB:   alu_op = ALU_SUB;
                    OP_AND:   alu_op = ALU_AND;
                    OP_OR:    alu_op = ALU_OR;
                    OP_XOR:   alu_op = ALU_XOR;
                    OP_CMPEQ: alu_op = ALU_EQ;
                    default:  alu_op = ALU_ADD;
                endcase
                state_d = F_ADDR;
            end
            E_WRITE: begin
                mem_write = 1'b1;
                state_d   = F_ADDR;
            end
            HALTED: begin
                halted = 1'b1;
                error  = error_q;
            end
            default: state_d = IDLE;
        endcase

        // Synchronous reset must already silence every strobe in the cycle it is asserted.
        if (reset) begin
            pc_write  = 1'b0;
            pc_sel    = 1'b0;
            mar_write = 1'b0;
            mar_sel   = 1'b0;
            mbr_write = 1'b0;
            mbr_sel   = 1'b0;
            ir_write  = 1'b0;
            acc_write = 1'b0;
            acc_sel   = 1'b0;
            mem_write = 1'b0;
            alu_op    = ALU_ADD;
            halted    = 1'b0;
            error     = 1'b0;
        end
    end

endmodule
